solver_start_ctrl: RTL and testbench

- Multi-channel start sequencer for the ODE solver cores (Euler and successors); the parametrised successor of the single-channel start FSM.
- Per channel: converts a start request into a registered start pulse of configurable width, then holds busy until that core's final_done.
- Adds an optional per-channel watchdog timeout with a sticky error flag, plus a done pulse.
- Sits between the top-level controller/host interface and NUM_CH solver cores.

---
 rtl/solver_start_pkg.sv | 29 ++
 rtl/solver_start_if.sv | 24 ++
 rtl/solver_start_ch_fsm.sv | 116 +++++++++++
 rtl/solver_start_ctrl.sv | 47 ++++
 tb/tb_solver_start_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/solver_start_pkg.sv
// Shared definitions for the multi-channel solver start sequencer:
// channel state encoding, default widths and a constant clog2 helper.
package solver_start_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PULSE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   // 2'd3 is unreachable; the channel FSM treats it as a request to return to IDLE
   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_PULSE = PULSE,
      ST_WAIT  = WAIT,
      ST_RSVD  = 2'd3
   } ch_state_e;

   localparam int DEF_PULSE_W = 1;
   localparam int DEF_TO_W    = 16;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/solver_start_if.sv
// Handshake bundle between the host-side controller and the start sequencer;
// the sequencer takes the slave view, the host/bench the master view.
interface solver_start_if #(
   parameter int NUM_CH = 1,
   parameter int TO_W   = 16
);
   logic [NUM_CH-1:0] start_req;
   logic [NUM_CH-1:0] final_done;
   logic [TO_W-1:0]   timeout_cycles;
   logic [NUM_CH-1:0] start_pulse;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] done_pulse;
   logic [NUM_CH-1:0] timeout_err;

   modport master (
      output start_req, final_done, timeout_cycles,
      input  start_pulse, busy, done_pulse, timeout_err
   );

   modport slave (
      input  start_req, final_done, timeout_cycles,
      output start_pulse, busy, done_pulse, timeout_err
   );
endinterface

// File: rtl/solver_start_ch_fsm.sv
// One start channel: request -> PULSE_W-cycle start pulse -> wait for the
// core's final_done, with an optional watchdog and sticky timeout flag.
module start_ch_fsm
   import solver_start_pkg::*;
#(
   parameter int PULSE_W   = DEF_PULSE_W,
   parameter int TO_W      = DEF_TO_W,
   parameter int EDGE_MODE = 0
) (
   input  logic            clk,
   input  logic            rst_async,
   input  logic            rst_sync,
   input  logic            start_req,
   input  logic            final_done,
   input  logic [TO_W-1:0] timeout_cycles,
   output logic            start_pulse,
   output logic            busy,
   output logic            done_pulse,
   output logic            timeout_err
);
   localparam int                PCNT_W    = clog2(PULSE_W + 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_W - 1);
   localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);

   ch_state_e         state_reg;
   logic [PCNT_W-1:0] pcnt_reg;
   logic [TO_W-1:0]   wd_cnt_reg;
   logic [TO_W-1:0]   limit_reg;
   logic              done_pending_reg;
   logic              start_req_q_reg;
   logic              start_pulse_reg;
   logic              busy_reg;
   logic              done_pulse_reg;
   logic              timeout_err_reg;
   logic              trigger;

   assign trigger = (EDGE_MODE != 0) ? (start_req & ~start_req_q_reg) : start_req;

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state_reg        <= ST_IDLE;
         pcnt_reg         <= '0;
         wd_cnt_reg       <= '0;
         limit_reg        <= '0;
         done_pending_reg <= 1'b0;
         start_req_q_reg  <= 1'b0;
         start_pulse_reg  <= 1'b0;
         busy_reg         <= 1'b0;
         done_pulse_reg   <= 1'b0;
         timeout_err_reg  <= 1'b0;
      end else if (rst_sync) begin
         state_reg        <= ST_IDLE;
         pcnt_reg         <= '0;
         wd_cnt_reg       <= '0;
         limit_reg        <= '0;
         done_pending_reg <= 1'b0;
         start_req_q_reg  <= 1'b0;
         start_pulse_reg  <= 1'b0;
         busy_reg         <= 1'b0;
         done_pulse_reg   <= 1'b0;
         timeout_err_reg  <= 1'b0;
      end else begin
         start_req_q_reg <= start_req;
         done_pulse_reg  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (trigger) begin
                  state_reg        <= ST_PULSE;
                  limit_reg        <= timeout_cycles;
                  timeout_err_reg  <= 1'b0;
                  pcnt_reg         <= '0;
                  done_pending_reg <= 1'b0;
                  start_pulse_reg  <= 1'b1;
                  busy_reg         <= 1'b1;
               end
            end
            ST_PULSE: begin
               // an early done is remembered so the pulse always runs full width
               if (final_done) done_pending_reg <= 1'b1;
               if (pcnt_reg == PCNT_LAST) begin
                  state_reg       <= ST_WAIT;
                  start_pulse_reg <= 1'b0;
                  wd_cnt_reg      <= '0;
               end else begin
                  pcnt_reg <= pcnt_reg + PCNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (final_done || done_pending_reg) begin
                  state_reg        <= ST_IDLE;
                  done_pending_reg <= 1'b0;
                  done_pulse_reg   <= 1'b1;
                  busy_reg         <= 1'b0;
               end else if ((limit_reg != '0) && (wd_cnt_reg == limit_reg - TO_ONE)) begin
                  state_reg       <= ST_IDLE;
                  timeout_err_reg <= 1'b1;
                  busy_reg        <= 1'b0;
               end else begin
                  wd_cnt_reg <= wd_cnt_reg + TO_ONE;
               end
            end
            default: begin
               state_reg       <= ST_IDLE;
               start_pulse_reg <= 1'b0;
               busy_reg        <= 1'b0;
            end
         endcase
      end
   end

   assign start_pulse = start_pulse_reg;
   assign busy        = busy_reg;
   assign done_pulse  = done_pulse_reg;
   assign timeout_err = timeout_err_reg;

endmodule

// File: rtl/solver_start_ctrl.sv
// Multi-channel start sequencer: NUM_CH independent start channels sharing
// clock, resets and the watchdog limit input.
module solver_start_ctrl
   import solver_start_pkg::*;
#(
   parameter int NUM_CH    = 1,
   parameter int PULSE_W   = DEF_PULSE_W,
   parameter int TO_W      = DEF_TO_W,
   parameter int EDGE_MODE = 0
) (
   input logic           clk,
   input logic           rst_async,
   input logic           rst_sync,
   solver_start_if.slave bus
);
   logic [NUM_CH-1:0] start_pulse_vec;
   logic [NUM_CH-1:0] busy_vec;
   logic [NUM_CH-1:0] done_pulse_vec;
   logic [NUM_CH-1:0] timeout_err_vec;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         start_ch_fsm #(
            .PULSE_W   (PULSE_W),
            .TO_W      (TO_W),
            .EDGE_MODE (EDGE_MODE)
         ) u_ch (
            .clk            (clk),
            .rst_async      (rst_async),
            .rst_sync       (rst_sync),
            .start_req      (bus.start_req[gi]),
            .final_done     (bus.final_done[gi]),
            .timeout_cycles (bus.timeout_cycles),
            .start_pulse    (start_pulse_vec[gi]),
            .busy           (busy_vec[gi]),
            .done_pulse     (done_pulse_vec[gi]),
            .timeout_err    (timeout_err_vec[gi])
         );
      end
   endgenerate

   assign bus.start_pulse = start_pulse_vec;
   assign bus.busy        = busy_vec;
   assign bus.done_pulse  = done_pulse_vec;
   assign bus.timeout_err = timeout_err_vec;

endmodule

// File: tb/tb_solver_start_ctrl.sv
// Directed bench: a 4-channel level-mode instance (PULSE_W=1) and a 2-channel
// edge-mode instance (PULSE_W=3), stepped one cycle at a time.
module tb_solver_start_ctrl;
   logic clk = 1'b0;
   logic rst_async = 1'b1;
   logic rst_sync = 1'b0;
   int   checks = 0;
   int   errors = 0;

   solver_start_if #(.NUM_CH(4), .TO_W(8)) ifa ();
   solver_start_if #(.NUM_CH(2), .TO_W(8)) ifb ();

   solver_start_ctrl #(.NUM_CH(4), .PULSE_W(1), .TO_W(8), .EDGE_MODE(0)) dut_a (
      .clk(clk), .rst_async(rst_async), .rst_sync(rst_sync), .bus(ifa.slave)
   );
   solver_start_ctrl #(.NUM_CH(2), .PULSE_W(3), .TO_W(8), .EDGE_MODE(1)) dut_b (
      .clk(clk), .rst_async(rst_async), .rst_sync(rst_sync), .bus(ifb.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [3:0] sp, input logic [3:0] bsy,
                        input logic [3:0] dp, input logic [3:0] err);
      chk({tag, ".start_pulse"}, 32'(ifa.start_pulse), 32'(sp));
      chk({tag, ".busy"},        32'(ifa.busy),        32'(bsy));
      chk({tag, ".done_pulse"},  32'(ifa.done_pulse),  32'(dp));
      chk({tag, ".timeout_err"}, 32'(ifa.timeout_err), 32'(err));
      $display("step %s: A sp=%b busy=%b done=%b err=%b", tag,
               ifa.start_pulse, ifa.busy, ifa.done_pulse, ifa.timeout_err);
   endtask

   task automatic chk_b(input string tag, input logic [1:0] sp, input logic [1:0] bsy,
                        input logic [1:0] dp, input logic [1:0] err);
      chk({tag, ".start_pulse"}, 32'(ifb.start_pulse), 32'(sp));
      chk({tag, ".busy"},        32'(ifb.busy),        32'(bsy));
      chk({tag, ".done_pulse"},  32'(ifb.done_pulse),  32'(dp));
      chk({tag, ".timeout_err"}, 32'(ifb.timeout_err), 32'(err));
      $display("step %s: B sp=%b busy=%b done=%b err=%b", tag,
               ifb.start_pulse, ifb.busy, ifb.done_pulse, ifb.timeout_err);
   endtask

   initial begin
      ifa.start_req = '0; ifa.final_done = '0; ifa.timeout_cycles = '0;
      ifb.start_req = '0; ifb.final_done = '0; ifb.timeout_cycles = '0;
      step(); step();
      chk_a("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0);
      chk_b("rst_hold", 2'h0, 2'h0, 2'h0, 2'h0);
      rst_async = 1'b0;
      step();
      chk_a("rst_rel", 4'h0, 4'h0, 4'h0, 4'h0);

      // basic run on channel 0
      ifa.start_req = 4'b0001; step(); chk_a("basic_pulse", 4'h1, 4'h1, 4'h0, 4'h0);
      ifa.start_req = 4'b0000; step(); chk_a("basic_wait", 4'h0, 4'h1, 4'h0, 4'h0);
      step(); step();                  chk_a("basic_wait2", 4'h0, 4'h1, 4'h0, 4'h0);
      ifa.final_done = 4'b0001; step(); chk_a("basic_done", 4'h0, 4'h0, 4'h1, 4'h0);
      ifa.final_done = 4'b0000; step(); chk_a("basic_idle", 4'h0, 4'h0, 4'h0, 4'h0);

      // watchdog on channel 1: limit 5 latched, input changed afterwards
      ifa.timeout_cycles = 8'd5; ifa.start_req = 4'b0010; step();
      chk_a("to_pulse", 4'h2, 4'h2, 4'h0, 4'h0);
      ifa.start_req = 4'b0000; ifa.timeout_cycles = 8'd0; step();
      chk_a("to_wait", 4'h0, 4'h2, 4'h0, 4'h0);
      repeat (4) step();
      chk_a("to_wait4", 4'h0, 4'h2, 4'h0, 4'h0);
      step(); chk_a("to_fire", 4'h0, 4'h0, 4'h0, 4'h2);
      step(); chk_a("to_sticky", 4'h0, 4'h0, 4'h0, 4'h2);
      ifa.start_req = 4'b0010; step(); chk_a("to_clear", 4'h2, 4'h2, 4'h0, 4'h0);
      ifa.start_req = 4'b0000; step();
      ifa.final_done = 4'b0010; step(); chk_a("to_rerun_done", 4'h0, 4'h0, 4'h2, 4'h0);
      ifa.final_done = 4'b0000;

      // done and timeout on the same edge on channel 2 (limit 2)
      ifa.timeout_cycles = 8'd2; ifa.start_req = 4'b0100; step();
      ifa.start_req = 4'b0000; ifa.timeout_cycles = 8'd0; step();
      step(); chk_a("tie_wait", 4'h0, 4'h4, 4'h0, 4'h0);
      ifa.final_done = 4'b0100; step(); chk_a("tie_done", 4'h0, 4'h0, 4'h4, 4'h0);
      ifa.final_done = 4'b0000;

      // level mode re-trigger on channel 3
      ifa.start_req = 4'b1000; step(); chk_a("lvl_pulse1", 4'h8, 4'h8, 4'h0, 4'h0);
      step(); chk_a("lvl_wait", 4'h0, 4'h8, 4'h0, 4'h0);
      ifa.final_done = 4'b1000; step(); chk_a("lvl_done", 4'h0, 4'h0, 4'h8, 4'h0);
      ifa.final_done = 4'b0000; step(); chk_a("lvl_pulse2", 4'h8, 4'h8, 4'h0, 4'h0);
      ifa.start_req = 4'b0000; step();
      ifa.final_done = 4'b1000; step(); chk_a("lvl_done2", 4'h0, 4'h0, 4'h8, 4'h0);
      ifa.final_done = 4'b0000; step(); chk_a("lvl_idle", 4'h0, 4'h0, 4'h0, 4'h0);
      ifa.final_done = 4'b1111; step(); chk_a("idle_done", 4'h0, 4'h0, 4'h0, 4'h0);
      ifa.final_done = 4'b0000; step(); chk_a("idle_done2", 4'h0, 4'h0, 4'h0, 4'h0);

      // staggered multi-channel traffic
      ifa.start_req = 4'b0001; step(); chk_a("mc_s0", 4'h1, 4'h1, 4'h0, 4'h0);
      ifa.start_req = 4'b0110; step(); chk_a("mc_s12", 4'h6, 4'h7, 4'h0, 4'h0);
      ifa.start_req = 4'b0000; step(); chk_a("mc_w", 4'h0, 4'h7, 4'h0, 4'h0);
      ifa.final_done = 4'b0110; ifa.start_req = 4'b1000; step();
      chk_a("mc_d12", 4'h8, 4'h9, 4'h6, 4'h0);
      ifa.final_done = 4'b0001; ifa.start_req = 4'b0000; step();
      chk_a("mc_d0", 4'h0, 4'h8, 4'h1, 4'h0);
      ifa.final_done = 4'b1000; step(); chk_a("mc_d3", 4'h0, 4'h0, 4'h8, 4'h0);
      ifa.final_done = 4'b0000; step(); chk_a("mc_idle", 4'h0, 4'h0, 4'h0, 4'h0);

      // edge mode, PULSE_W=3, done during the pulse, start_req held high
      ifb.start_req = 2'b01; step(); chk_b("pw_p1", 2'h1, 2'h1, 2'h0, 2'h0);
      step(); chk_b("pw_p2", 2'h1, 2'h1, 2'h0, 2'h0);
      ifb.final_done = 2'b01; step(); chk_b("pw_p3", 2'h1, 2'h1, 2'h0, 2'h0);
      ifb.final_done = 2'b00; step(); chk_b("pw_wait", 2'h0, 2'h1, 2'h0, 2'h0);
      step(); chk_b("pw_done", 2'h0, 2'h0, 2'h1, 2'h0);
      step(); chk_b("edge_held", 2'h0, 2'h0, 2'h0, 2'h0);
      step(); chk_b("edge_held2", 2'h0, 2'h0, 2'h0, 2'h0);
      ifb.start_req = 2'b00; step();

      // rising edge during WAIT on channel 1 is lost
      ifb.start_req = 2'b10; step(); chk_b("ew_pulse", 2'h2, 2'h2, 2'h0, 2'h0);
      ifb.start_req = 2'b00; step(); step(); step();
      chk_b("ew_wait", 2'h0, 2'h2, 2'h0, 2'h0);
      ifb.start_req = 2'b10; step(); chk_b("ew_ign", 2'h0, 2'h2, 2'h0, 2'h0);
      ifb.final_done = 2'b10; step(); chk_b("ew_done", 2'h0, 2'h0, 2'h2, 2'h0);
      ifb.final_done = 2'b00; step(); chk_b("ew_lost", 2'h0, 2'h0, 2'h0, 2'h0);
      ifb.start_req = 2'b00; step();

      // one-cycle watchdog on channel 1 so reset has a flag to clear
      ifb.timeout_cycles = 8'd1; ifb.start_req = 2'b10; step();
      ifb.start_req = 2'b00; ifb.timeout_cycles = 8'd0;
      step(); step(); step(); step();
      chk_b("b_to", 2'h0, 2'h0, 2'h0, 2'h2);

      // asynchronous reset in the middle of a pulse
      ifb.start_req = 2'b01; step(); chk_b("ra_pulse", 2'h1, 2'h1, 2'h0, 2'h2);
      ifb.start_req = 2'b00;
      #1; rst_async = 1'b1; #1;
      chk_b("ra_async", 2'h0, 2'h0, 2'h0, 2'h0);
      step(); rst_async = 1'b0;
      step(); chk_b("ra_after", 2'h0, 2'h0, 2'h0, 2'h0);
      ifb.start_req = 2'b01; step(); chk_b("ra_restart", 2'h1, 2'h1, 2'h0, 2'h0);

      // synchronous clear in the middle of WAIT
      ifb.start_req = 2'b00; step(); step(); step();
      chk_b("rs_wait", 2'h0, 2'h1, 2'h0, 2'h0);
      rst_sync = 1'b1; step(); chk_b("rs_clear", 2'h0, 2'h0, 2'h0, 2'h0);
      rst_sync = 1'b0;
      ifb.final_done = 2'b01; step(); chk_b("rs_nodone", 2'h0, 2'h0, 2'h0, 2'h0);
      ifb.final_done = 2'b00;
      ifb.start_req = 2'b01; step(); chk_b("rs_restart", 2'h1, 2'h1, 2'h0, 2'h0);
      ifb.start_req = 2'b00;
      chk_a("a_quiet", 4'h0, 4'h0, 4'h0, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
